// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if: request/response handshake between a client and ram_ctrl
interface ram_ctrl_if #(parameter int AW = 9, parameter int DW = 32);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  modport master (output req_valid, req_we, req_addr, req_wdata, input req_ready, rsp_valid, rsp_rdata);
  modport slave  (input req_valid, req_we, req_addr, req_wdata, output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/ram_ctrl.sv
// ram_ctrl: sequences single-word requests and zero-fill clears into registered re/we strobes on an async RAM
module ram_ctrl #(parameter int AW = 9, parameter int DW = 32) (
  input  logic                clk,
  input  logic                rst,
  ram_ctrl_if.slave           bus,
  input  logic                clr_start,
  output logic                clr_busy,
  output logic                clr_done,
  output logic                ram_re,
  output logic                ram_we,
  output logic [AW-1:0]       ram_addr,
  inout  wire logic [DW-1:0]  ram_data
);
  typedef enum logic [3:0] {
    IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_PULSE, R_CAPT, TURN, C_SETUP, C_PULSE, C_HOLD
  } state_t;
  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d, rdata_q, rdata_d;
  logic          re_q, re_d, we_q, we_d, oe_q, oe_d;
  logic          rsp_q, rsp_d, done_q, done_d, busy_q, busy_d;
  logic          acc;
  assign bus.req_ready = state_q == IDLE && !clr_start;
  assign acc = bus.req_valid && bus.req_ready;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        state_d = clr_start ? C_SETUP : acc ? (bus.req_we ? W_SETUP : R_SETUP) : IDLE;
      end
      W_SETUP: state_d = W_PULSE;
      W_PULSE: state_d = W_HOLD;
      W_HOLD:  state_d = IDLE;
      R_SETUP: state_d = R_PULSE;
      R_PULSE: state_d = R_CAPT;
      R_CAPT:  state_d = TURN;
      TURN:    state_d = IDLE;
      C_SETUP: state_d = C_PULSE;
      C_PULSE: state_d = C_HOLD;
      C_HOLD: begin
        // the extra counter bit marks the pass over the last word, so the sweep never wraps
        cnt_d = cnt_q + {{AW{1'b0}}, 1'b1};
        state_d = cnt_d[AW] ? IDLE : C_SETUP;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d inside {C_SETUP, C_PULSE, C_HOLD};
    re_d = state_d inside {R_PULSE, R_CAPT};
    we_d = state_d inside {W_PULSE, C_PULSE};
    oe_d = busy_d || state_d inside {W_SETUP, W_PULSE, W_HOLD};
    addr_d = busy_d ? cnt_d[AW-1:0] : acc ? bus.req_addr : addr_q;
    dout_d = busy_d ? '0 : acc ? bus.req_wdata : dout_q;
    rdata_d = state_q == R_CAPT ? ram_data : rdata_q;
    rsp_d = state_d == TURN;
    done_d = state_q == C_HOLD && state_d == IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      rsp_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      re_q    <= re_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
      rsp_q   <= rsp_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end
  assign ram_re = re_q;
  assign ram_we = we_q;
  assign ram_addr = addr_q;
  assign ram_data = oe_q ? dout_q : 'z;
  assign bus.rsp_valid = rsp_q;
  assign bus.rsp_rdata = rdata_q;
  assign clr_busy = busy_q;
  assign clr_done = done_q;
endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed vectors for ram_ctrl against a behavioural 512x32 async RAM
module tb_ram_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_start = 1'b0;
  logic        clr_busy, clr_done, ram_re, ram_we;
  logic [8:0]  ram_addr;
  wire  [31:0] ram_data;
  logic [31:0] mem [512];
  ram_ctrl_if #(.AW(9), .DW(32)) bus ();
  ram_ctrl #(.AW(9), .DW(32)) dut (
    .clk(clk), .rst(rst), .bus(bus), .clr_start(clr_start), .clr_busy(clr_busy),
    .clr_done(clr_done), .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data)
  );
  assign ram_data = ram_re ? mem[ram_addr] : 'z;
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_data;
  int cyc = 0, n_vec = 0, n_err = 0;
  int we_cnt = 0, last_we = -1, rsp_cnt = 0, last_rsp = -1, done_cnt = 0, last_done = -1;
  int busy_cnt = 0, ov_cnt = 0, mv_cnt = 0;
  logic [31:0] last_rdata = '0;
  logic [31:0] rsp_q [$];
  logic        prev_act = 1'b0;
  logic [8:0]  prev_addr = '0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt <= we_cnt + 1;
      last_we <= cyc;
    end
    if (bus.rsp_valid) begin
      rsp_cnt <= rsp_cnt + 1;
      last_rsp <= cyc;
      last_rdata <= bus.rsp_rdata;
      rsp_q.push_back(bus.rsp_rdata);
    end
    if (clr_done) begin
      done_cnt <= done_cnt + 1;
      last_done <= cyc;
    end
    if (clr_busy) busy_cnt <= busy_cnt + 1;
    if (ram_re && ram_we) ov_cnt <= ov_cnt + 1;
    if ((ram_re || ram_we) && prev_act && ram_addr != prev_addr) mv_cnt <= mv_cnt + 1;
    prev_act <= ram_re || ram_we;
    prev_addr <= ram_addr;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] bus_idle();
    return 32'($isunknown(ram_data) || ram_data == '0);
  endfunction
  task automatic issue(input logic we, input logic [8:0] a, input logic [31:0] d, output int t);
    int i = 0;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = a;
    bus.req_wdata = d;
    #1;
    while (!bus.req_ready && i < 2000) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (!bus.req_ready) chk("accept_timeout", 0, 1);
    t = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr = ~a;
    bus.req_wdata = ~d;
  endtask
  task automatic do_write(input logic [8:0] a, input logic [31:0] d);
    int t, w0;
    w0 = we_cnt;
    issue(1'b1, a, d, t);
    repeat (3) @(negedge clk);
    chk("wr_ready", 32'(bus.req_ready), 1);
    chk("wr_we_cyc", last_we - t, 2);
    chk("wr_we_cnt", we_cnt - w0, 1);
  endtask
  task automatic do_read(input logic [8:0] a, input logic [31:0] exp, output int t);
    int r0;
    r0 = rsp_cnt;
    issue(1'b0, a, '0, t);
    repeat (4) @(negedge clk);
    chk("rd_lat", last_rsp - t, 4);
    chk("rd_data", last_rdata, exp);
    chk("rd_cnt", rsp_cnt - r0, 1);
    chk("rd_ready", 32'(bus.req_ready), 1);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 1);
    chk({tag, "_rsp"}, 32'(bus.rsp_valid), 0);
    chk({tag, "_rdata"}, bus.rsp_rdata, 0);
    chk({tag, "_busy"}, 32'(clr_busy), 0);
    chk({tag, "_done"}, 32'(clr_done), 0);
    chk({tag, "_re"}, 32'(ram_re), 0);
    chk({tag, "_we"}, 32'(ram_we), 0);
    chk({tag, "_addr"}, 32'(ram_addr), 0);
    chk({tag, "_bus"}, bus_idle(), 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t, t0, t1, t2, t3, tc, w0, r0, b0, d0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst0");
    rst = 1'b0;
    @(negedge clk);
    do_write(9'd0, 32'h1);
    do_write(9'd4, 32'h10);
    do_read(9'd0, 32'h1, t);
    do_read(9'd4, 32'h10, t);
    rsp_q.delete();
    w0 = we_cnt;
    issue(1'b1, 9'd1, 32'hA5A5A5A5, t0);
    issue(1'b0, 9'd1, '0, t1);
    issue(1'b1, 9'd1, 32'h5A5A5A5A, t2);
    issue(1'b0, 9'd1, '0, t3);
    repeat (5) @(negedge clk);
    chk("bb_w_to_r", t1 - t0, 4);
    chk("bb_r_to_w", t2 - t1, 5);
    chk("bb_w_to_r2", t3 - t2, 4);
    chk("bb_nrsp", rsp_q.size(), 2);
    chk("bb_rd0", rsp_q[0], 32'hA5A5A5A5);
    chk("bb_rd1", rsp_q[1], 32'h5A5A5A5A);
    chk("bb_we", we_cnt - w0, 2);
    do_write(9'd511, 32'hDEADBEEF);
    b0 = busy_cnt;
    d0 = done_cnt;
    clr_start = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_addr = 9'd511;
    #1;
    chk("clr_pri_ready", 32'(bus.req_ready), 0);
    tc = cyc;
    @(negedge clk);
    clr_start = 1'b0;
    do_read(9'd511, 32'h0, t);
    chk("clr_accept", t - tc, 1537);
    chk("clr_done_cyc", last_done - tc, 1537);
    chk("clr_done_n", done_cnt - d0, 1);
    chk("clr_busy_n", busy_cnt - b0, 1536);
    do_read(9'd0, 32'h0, t);
    do_read(9'd255, 32'h0, t);
    issue(1'b1, 9'd5, 32'h12345678, t);
    for (int k = 0; k < 3; k++) begin
      chk("lat_addr", 32'(ram_addr), 5);
      chk("lat_data", ram_data, 32'h12345678);
      @(negedge clk);
    end
    do_read(9'd5, 32'h12345678, t);
    do_write(9'd3, 32'h7);
    do_read(9'd3, 32'h7, t);
    issue(1'b1, 9'd3, 32'h99, t);
    @(negedge clk);
    chk("rw_pulse", 32'(ram_we), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("rw");
    rst = 1'b0;
    @(negedge clk);
    r0 = rsp_cnt;
    issue(1'b0, 9'd3, '0, t);
    repeat (2) @(negedge clk);
    chk("rc_re", 32'(ram_re), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rc_rsp", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    chk("rc_ready", 32'(bus.req_ready), 1);
    repeat (5) @(negedge clk);
    chk("rc_nrsp", rsp_cnt - r0, 0);
    chk("rc_rdata", bus.rsp_rdata, 0);
    d0 = done_cnt;
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    repeat (100) @(negedge clk);
    chk("mc_busy", 32'(clr_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mc_busy_off", 32'(clr_busy), 0);
    @(negedge clk);
    chk("mc_ready", 32'(bus.req_ready), 1);
    repeat (1600) @(negedge clk);
    chk("mc_ndone", done_cnt - d0, 0);
    chk("re_we_overlap", ov_cnt, 0);
    chk("addr_moved", mv_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Synchronous sequencer placed directly upstream of the 512 x 32 asynchronous `RAM` block. It accepts single-word read/write requests over a valid/ready handshake and turns each into a glitch-free `re`/`we` strobe sequence on the RAM's shared tristate data bus. It also provides a whole-memory clear operation. It is the only driver of the RAM's control, address and data pins.

## Interface
Parameters:
- `AW`, 9: RAM address width (depth = 2^AW words)
- `DW`, 32: data width

Ports:
- `clk`  in  1  single system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept a request this cycle
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  AW  word address
- `req_wdata`  in  DW  write data
- `rsp_valid`  out  1  one-cycle pulse: `rsp_rdata` holds read result
- `rsp_rdata`  out  DW  read data, held until next read completes
- `clr_start`  in  1  request zero-fill of all 2^AW words
- `clr_busy`  out  1  clear in progress
- `clr_done`  out  1  one-cycle pulse when clear finishes
- `ram_re`  out  1  RAM output enable
- `ram_we`  out  1  RAM write enable
- `ram_addr`  out  AW  RAM address
- `ram_data`  inout  DW  shared RAM data bus; driven only during write states, else `'z`

## Operation
- States: IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_PULSE, R_CAPT, TURN, C_SETUP, C_PULSE, C_HOLD.
- `req_ready` = 1 only in IDLE with `clr_start` = 0. Handshake occurs when `req_valid & req_ready`. Request fields are latched on acceptance and may change afterwards.
- Write path: IDLE -> W_SETUP -> W_PULSE -> W_HOLD -> IDLE.
  - Address and data are driven in all three states.
  - `ram_we` = 1 only in W_PULSE.
- Read path: IDLE -> R_SETUP -> R_PULSE -> R_CAPT -> TURN -> IDLE.
  - `ram_re` = 1 in R_PULSE and R_CAPT.
  - `ram_data` is sampled into `rsp_rdata` at the end of R_CAPT.
  - `rsp_valid` = 1 during TURN only.
  - TURN has `re` = 0 and the bus undriven, which guarantees a bus turnaround before any following write.
- Clear path: in IDLE, `clr_start` = 1 has priority over `req_valid`.
  - Flow: C_SETUP -> C_PULSE -> C_HOLD, repeated for address 0 through 2^AW-1 with data 0 and `ram_we` pulsed in C_PULSE.
  - An AW+1-bit counter sets `ram_addr`. After C_HOLD of address 2^AW-1, the FSM goes to IDLE and pulses `clr_done`.
  - The counter must not wrap to 0 and rewrite.
  - `clr_start` outside IDLE is ignored.
- Invariants:
  - `ram_re` and `ram_we` are never 1 in the same cycle.
  - `ram_data` is never driven while `ram_re` = 1.
  - `ram_addr` never changes while `ram_re` or `ram_we` = 1.
- All RAM-side outputs are registered (no combinational path from request inputs).

## Timing
- Reset values:
  - state IDLE
  - `req_ready` = 1 (when `clr_start` = 0)
  - `rsp_valid`, `clr_busy`, `clr_done`, `ram_re`, `ram_we` = 0
  - `ram_addr` = 0, `rsp_rdata` = 0, `ram_data` = `'z`
- Write accepted at cycle T:
  - `ram_we` high in T+2.
  - `req_ready` high again in T+4. Throughput is 1 write per 4 cycles.
- Read accepted at cycle T:
  - `ram_re` high in T+2 and T+3.
  - `rsp_valid` high in T+4.
  - `req_ready` high in T+5. Throughput is 1 read per 5 cycles.
- Clear started at cycle T:
  - `clr_busy` high from T+1 through T+3·2^AW.
  - `clr_done` high in T+3·2^AW+1 (cycle 1537 for AW = 9), coincident with `req_ready` returning high.
- `rst` asserted mid-operation: the next edge forces the reset values.
  - An in-flight write strobe is cut and the bus is released.
  - A pending read response is dropped (no `rsp_valid`).
  - An aborted clear produces no `clr_done`.
- `req_valid` held high with `req_ready` = 0 is not accepted and is not lost. It is accepted on the first IDLE cycle.

## Test plan
- Reset, then write 0x0000_0001 to addr 0 and 0x0000_0010 to addr 4, then read both.
  - Required: `rsp_rdata` = 0x1, then 0x10.
  - Required: `ram_we` exactly 1 cycle per write.
  - Required: `rsp_valid` 4 cycles after each read acceptance.
- Back-to-back stream with `req_valid` held high: W(1, 0xA5A5A5A5), R(1), W(1, 0x5A5A5A5A), R(1).
  - Required: reads return 0xA5A5A5A5, then 0x5A5A5A5A.
  - Required: assertion checker sees no cycle with `ram_data` driven while `ram_re` = 1, and no re/we overlap.
- Write 0xDEADBEEF to addr 511, pulse `clr_start` together with a pending `req_valid` read of addr 511.
  - Required: clear runs first.
  - Required: `clr_done` at cycle 1537 after start.
  - Required: the read then returns 0, and a sample of addrs 0, 255 and 511 reads 0.
- Assert `rst` during W_PULSE of a write to addr 3 (previously holding 0x7).
  - Required: `ram_we` = 0 and bus is `'z` the following cycle.
  - Required: all outputs are at their reset values.
- Assert `rst` during R_CAPT, and separately mid-clear.
  - Required: no `rsp_valid` and no `clr_done` pulse.
  - Required: `req_ready` = 1 the cycle after reset deasserts.
- Change `req_addr`/`req_wdata` on the cycle after acceptance.
  - Required: `ram_addr`/`ram_data` keep the latched values for the whole sequence.
